// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and the command decoder.
// The receiver drives data/valid and the consumer drives ready.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a majority-voted mid-bit sample, break handling
// and a single-byte holding register that flags overrun.
module uart_rx #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int BIT_CYCLES = CLK_HZ / BAUD,
   parameter int HALF       = BIT_CYCLES / 2
) (
   input  logic      clk,
   input  logic      nrst,
   input  logic      rxd,
   uart_rx_if.master rx_if,
   output logic      frame_err,
   output logic      overrun,
   output logic      busy
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
   localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BRK
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync1_d;
   logic          rxd_s_q, rxd_s_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bidx_q, bidx_d;
   logic [1:0]    samp_q, samp_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          busy_q, busy_d;

   logic          bit_end;
   logic          decide;
   logic          maj;
   logic          deliver;

   always_comb begin
      state_d     = state_q;
      sync1_d     = rxd;
      rxd_s_d     = sync1_q;
      bidx_d      = bidx_q;
      samp_d      = samp_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      deliver     = 1'b0;

      bit_end = (cnt_q == CNT_LAST);
      decide  = (cnt_q == CNT_DEC);
      maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);
      cnt_d   = bit_end ? '0 : cnt_q + 1'b1;

      if (cnt_q == CNT_S0) samp_d[0] = rxd_s_q;
      if (cnt_q == CNT_S1) samp_d[1] = rxd_s_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rxd_s_q) state_d = ST_START;
         end
         ST_START: begin
            if (decide && maj) begin
               state_d = ST_IDLE;
            end else if (bit_end) begin
               state_d = ST_DATA;
               bidx_d  = 3'd0;
            end
         end
         ST_DATA: begin
            if (decide) shift_d = {maj, shift_q[7:1]};
            if (bit_end) begin
               if (bidx_q == 3'd7) state_d = ST_STOP;
               else                bidx_d  = bidx_q + 3'd1;
            end
         end
         ST_STOP: begin
            // Leave at mid-stop so a start bit right after the stop bit is seen.
            if (decide) begin
               if (maj) begin
                  deliver = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BRK;
               end
            end
         end
         ST_BRK: begin
            cnt_d = '0;
            if (rxd_s_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (deliver) begin
         if (!rx_valid_q || rx_if.rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rx_if.rx_ready) begin
         rx_valid_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_IDLE;
         sync1_q     <= 1'b1;
         rxd_s_q     <= 1'b1;
         cnt_q       <= '0;
         bidx_q      <= '0;
         samp_q      <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rxd_s_q     <= rxd_s_d;
         cnt_q       <= cnt_d;
         bidx_q      <= bidx_d;
         samp_q      <= samp_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_if.rx_data  = rx_data_q;
   assign rx_if.rx_valid = rx_valid_q;
   assign frame_err      = frame_err_q;
   assign overrun        = overrun_q;
   assign busy           = busy_q;

endmodule
